// File: rtl/tb_irq_timer_bank_if.sv
// Data-bus bundle between the core-side bus master and the irq timer bank.
// Latency: none; wires only.
// Backpressure: gnt/rvalid are driven by the slave, the master never stalls a response.
interface tb_irq_timer_bank_if;
  logic        req_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/tb_irq_timer_bank.sv
// NUM_IRQ memory-mapped down-counting timers with maskable pending bits and fixed-priority irq/irq_id.
// Latency: bus response one cycle after grant; irq rises L+2 cycles after enable with LOAD=L; ack clears next cycle.
// Backpressure: none; gnt follows req combinationally and one access per cycle is sustained.
module tb_irq_timer_bank #(
  parameter int unsigned NUM_IRQ   = 4,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned ID_WIDTH  = 5,
  parameter int unsigned ID_OFFSET = 16,
  parameter logic [31:0] BASE_ADDR = 32'h1500_0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  tb_irq_timer_bank_if.slave  bus,
  output logic                irq_o,
  output logic [ID_WIDTH-1:0] irq_id_o,
  input  logic                irq_ack_i,
  input  logic [ID_WIDTH-1:0] irq_id_i,
  output logic [NUM_IRQ-1:0]  pending_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_e;

  ch_state_e            state_q [NUM_IRQ];
  logic [CNT_WIDTH-1:0] load_q  [NUM_IRQ];
  logic [CNT_WIDTH-1:0] count_q [NUM_IRQ];
  logic [NUM_IRQ-1:0]   periodic_q;
  logic [NUM_IRQ-1:0]   pend_q, pend_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic [NUM_IRQ-1:0]   masked;
  logic                 rvalid_q;
  logic [31:0]          rdata_q, rdata_d;

  logic                 win_hit;
  logic                 wr_en;
  logic [7:0]           word;
  logic [4:0]           ch_sel;
  logic [1:0]           reg_sel;
  logic                 ch_valid;
  logic [NUM_IRQ-1:0]   wr_load, wr_ctrl, w1c, expire, ack_hit;

  // Merge write data into an existing word under byte enables.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Misaligned addresses are treated as unmapped so every access maps to exactly one word.
  assign win_hit  = bus.req_i && (bus.addr_i[31:10] == BASE_ADDR[31:10]) && (bus.addr_i[1:0] == 2'b00);
  assign wr_en    = win_hit && bus.we_i;
  assign word     = bus.addr_i[9:2];
  assign ch_sel   = word[6:2];
  assign reg_sel  = word[1:0];
  assign ch_valid = win_hit && !word[7] && (32'(ch_sel) < NUM_IRQ);

  // Per-channel write strobes, timer expiry and ack match.
  always_comb begin
    wr_load = '0;
    wr_ctrl = '0;
    w1c     = '0;
    expire  = '0;
    ack_hit = '0;
    for (int n = 0; n < NUM_IRQ; n++) begin
      wr_load[n] = wr_en && ch_valid && (ch_sel == 5'(n)) && (reg_sel == 2'd0);
      wr_ctrl[n] = wr_en && ch_valid && (ch_sel == 5'(n)) && (reg_sel == 2'd1) && bus.be_i[0];
      w1c[n]     = wr_en && ch_valid && (ch_sel == 5'(n)) && (reg_sel == 2'd3) && bus.be_i[0] && bus.wdata_i[0];
      expire[n]  = (state_q[n] == RUN) && (count_q[n] == '0);
      ack_hit[n] = irq_ack_i && (irq_id_i == ID_WIDTH'(ID_OFFSET + n));
    end
  end

  // Expiry takes precedence over a same-cycle ack or W1C so no event is lost.
  always_comb begin
    pend_d = expire | (pend_q & ~(ack_hit | w1c));
    mask_d = mask_q;
    if (wr_en && (word == 8'h81)) mask_d = NUM_IRQ'(be_merge(32'(mask_q), bus.wdata_i, bus.be_i));
  end

  // Channel FSMs: a CTRL write overrides the running countdown; LOAD only feeds future reloads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      periodic_q <= '0;
      for (int n = 0; n < NUM_IRQ; n++) begin
        state_q[n] <= IDLE;
        load_q[n]  <= '0;
        count_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_IRQ; n++) begin
        if (wr_load[n]) load_q[n] <= CNT_WIDTH'(be_merge(32'(load_q[n]), bus.wdata_i, bus.be_i));
        if (wr_ctrl[n]) begin
          periodic_q[n] <= bus.wdata_i[1];
          if (bus.wdata_i[0]) begin
            state_q[n] <= RUN;
            count_q[n] <= load_q[n];
          end else begin
            state_q[n] <= IDLE;
          end
        end else begin
          case (state_q[n])
            RUN: begin
              if (count_q[n] == '0) begin
                if (periodic_q[n]) count_q[n] <= load_q[n];
                else               state_q[n] <= IDLE;
              end else begin
                count_q[n] <= count_q[n] - CNT_WIDTH'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Pending and mask registers; mask comes out of reset fully open.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      mask_q <= '1;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  // Read mux; anything outside the decoded registers reads as zero.
  always_comb begin
    rdata_d = '0;
    if (win_hit && !bus.we_i) begin
      if (ch_valid) begin
        for (int n = 0; n < NUM_IRQ; n++) begin
          if (ch_sel == 5'(n)) begin
            case (reg_sel)
              2'd0:    rdata_d = 32'(load_q[n]);
              2'd1:    rdata_d = {30'b0, periodic_q[n], state_q[n] == RUN};
              2'd2:    rdata_d = 32'(count_q[n]);
              default: rdata_d = {31'b0, pend_q[n]};
            endcase
          end
        end
      end else if (word == 8'h80) begin
        rdata_d = 32'(pend_q);
      end else if (word == 8'h81) begin
        rdata_d = 32'(mask_q);
      end
    end
  end

  // Single-cycle response pipeline; reset drops an in-flight response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= bus.req_i;
      rdata_q  <= rdata_d;
    end
  end

  // Lowest-index masked pending channel wins; id is zero when nothing is requesting.
  always_comb begin
    irq_id_o = '0;
    for (int n = int'(NUM_IRQ) - 1; n >= 0; n--) begin
      if (masked[n]) irq_id_o = ID_WIDTH'(ID_OFFSET + n);
    end
  end

  assign masked       = pend_q & mask_q;
  assign irq_o        = |masked;
  assign pending_o    = pend_q;
  assign bus.gnt_o    = bus.req_i;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;

endmodule

// File: tb/tb_tb_irq_timer_bank.sv
// Bench for tb_irq_timer_bank: directed feature scenarios plus a randomized run against an arithmetic model.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 1ns after it or at the falling edge.
// Backpressure: none exercised; the bank grants every request.
module tb_tb_irq_timer_bank;
  localparam int NUM_IRQ   = 4;
  localparam int CNT_WIDTH = 32;
  localparam int ID_WIDTH  = 5;
  localparam int ID_OFFSET = 16;
  localparam logic [31:0] BASE = 32'h1500_0000;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                irq_o;
  logic [ID_WIDTH-1:0] irq_id_o;
  logic                irq_ack_i = 1'b0;
  logic [ID_WIDTH-1:0] irq_id_i = '0;
  logic [NUM_IRQ-1:0]  pending_o;

  int n_pass  = 0;
  int n_total = 0;

  int rl   [NUM_IRQ];
  bit rper [NUM_IRQ];

  tb_irq_timer_bank_if bus ();

  tb_irq_timer_bank #(
    .NUM_IRQ  (NUM_IRQ),
    .CNT_WIDTH(CNT_WIDTH),
    .ID_WIDTH (ID_WIDTH),
    .ID_OFFSET(ID_OFFSET),
    .BASE_ADDR(BASE)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bus      (bus),
    .irq_o    (irq_o),
    .irq_id_o (irq_id_o),
    .irq_ack_i(irq_ack_i),
    .irq_id_i (irq_id_i),
    .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ra(input int n, input int r);
    return BASE + 32'(16 * n) + 32'(4 * r);
  endfunction

  // Cycle c (relative to the first enable write) in which channel n shows a fresh pending bit.
  function automatic bit fires(input int n, input int c);
    int first;
    first = n + rl[n] + 2;
    if (c < first) return 1'b0;
    if (rper[n]) return ((c - first) % (rl[n] + 1)) == 0;
    return c == first;
  endfunction

  task automatic tick(input int k);
    repeat (k) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(3);
    rst_i = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.wdata_i = d; bus.be_i = be;
    tick(1);
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a; bus.be_i = 4'hF;
    tick(1);
    bus.req_i = 1'b0; bus.be_i = 4'h0;
    d = (bus.rvalid_o === 1'b1) ? bus.rdata_o : 32'hBAD0_BAD0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    n_total++; if ({irq_o, irq_id_o, pending_o, bus.rvalid_o} !== '0) $display("FAIL reset_outputs: got irq=%0b id=%0d pend=%0h rvalid=%0b, expected all 0", irq_o, irq_id_o, pending_o, bus.rvalid_o); else n_pass++;
    bus_write(ra(0, 0), 32'd100, 4'hF);
    bus_write(ra(0, 1), 32'h1, 4'h1);
    tick(4);
    bus_read(ra(0, 2), d);
    n_total++; if (d !== 32'd96) $display("FAIL count_running: got %0d expected 96", d); else n_pass++;
    rst_i = 1'b1;
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = ra(0, 2);
    tick(1);
    bus.req_i = 1'b0;
    n_total++; if ({bus.rvalid_o, bus.rdata_o, irq_o, irq_id_o, pending_o} !== '0) $display("FAIL reset_drops_rvalid: got rvalid=%0b rdata=%0h irq=%0b pend=%0h, expected 0", bus.rvalid_o, bus.rdata_o, irq_o, pending_o); else n_pass++;
    tick(2);
    rst_i = 1'b0;
    bus_read(BASE + 32'h204, d);
    n_total++; if (d !== 32'h0000_000F) $display("FAIL reset_mask: got %0h expected f", d); else n_pass++;
    bus_read(ra(0, 2), d);
    n_total++; if (d !== 32'h0) $display("FAIL reset_count: got %0h expected 0", d); else n_pass++;
    bus_read(ra(0, 1), d);
    n_total++; if (d !== 32'h0) $display("FAIL reset_ctrl: got %0h expected 0", d); else n_pass++;
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    bus_write(ra(0, 0), 32'd5, 4'hF);
    bus_write(ra(0, 1), 32'h1, 4'h1);
    tick(5);
    n_total++; if (irq_o !== 1'b0) $display("FAIL oneshot_early: got irq=%0b expected 0 at T+6", irq_o); else n_pass++;
    tick(1);
    n_total++; if ({irq_o, irq_id_o, pending_o} !== {1'b1, 5'd16, 4'b0001}) $display("FAIL oneshot_fire: got irq=%0b id=%0d pend=%0h expected 1/16/1", irq_o, irq_id_o, pending_o); else n_pass++;
    irq_ack_i = 1'b1; irq_id_i = 5'd16;
    tick(1);
    irq_ack_i = 1'b0;
    n_total++; if ({irq_o, irq_id_o, pending_o} !== '0) $display("FAIL oneshot_ack: got irq=%0b id=%0d pend=%0h expected 0", irq_o, irq_id_o, pending_o); else n_pass++;
    bus_read(ra(0, 1), d);
    n_total++; if (d !== 32'h0) $display("FAIL oneshot_ctrl_clear: got %0h expected 0", d); else n_pass++;
  endtask

  task automatic test_periodic();
    bus_write(ra(1, 0), 32'd3, 4'hF);
    bus_write(ra(1, 1), 32'h3, 4'h1);
    tick(3);
    n_total++; if (pending_o[1] !== 1'b0) $display("FAIL periodic_early: got %0b expected 0", pending_o[1]); else n_pass++;
    tick(1);
    n_total++; if (pending_o[1] !== 1'b1) $display("FAIL periodic_first: got %0b expected 1", pending_o[1]); else n_pass++;
    tick(1);
    bus_write(ra(1, 3), 32'h1, 4'h1);
    n_total++; if (pending_o[1] !== 1'b0) $display("FAIL periodic_w1c: got %0b expected 0", pending_o[1]); else n_pass++;
    tick(1);
    bus_write(ra(1, 3), 32'h1, 4'h1);
    n_total++; if (pending_o[1] !== 1'b1) $display("FAIL periodic_w1c_vs_expiry: got %0b expected 1", pending_o[1]); else n_pass++;
    bus_write(ra(1, 3), 32'h1, 4'h1);
    tick(2);
    n_total++; if (pending_o[1] !== 1'b0) $display("FAIL periodic_gap: got %0b expected 0", pending_o[1]); else n_pass++;
    tick(1);
    n_total++; if (pending_o[1] !== 1'b1) $display("FAIL periodic_third: got %0b expected 1", pending_o[1]); else n_pass++;
    bus_write(ra(1, 1), 32'h0, 4'h1);
    bus_write(ra(1, 3), 32'h1, 4'h1);
    n_total++; if (pending_o !== 4'h0) $display("FAIL periodic_stop: got %0h expected 0", pending_o); else n_pass++;
  endtask

  task automatic test_priority_mask();
    logic [31:0] d;
    do_reset();
    bus_write(ra(2, 1), 32'h1, 4'h1);
    bus_write(ra(3, 1), 32'h1, 4'h1);
    tick(2);
    n_total++; if ({pending_o, irq_o, irq_id_o} !== {4'hC, 1'b1, 5'd18}) $display("FAIL prio_both: got pend=%0h irq=%0b id=%0d expected c/1/18", pending_o, irq_o, irq_id_o); else n_pass++;
    bus_write(BASE + 32'h204, 32'h8, 4'hF);
    n_total++; if ({irq_o, irq_id_o} !== {1'b1, 5'd19}) $display("FAIL prio_mask8: got irq=%0b id=%0d expected 1/19", irq_o, irq_id_o); else n_pass++;
    bus_write(BASE + 32'h204, 32'h0, 4'hF);
    n_total++; if ({irq_o, irq_id_o} !== '0) $display("FAIL prio_mask0: got irq=%0b id=%0d expected 0/0", irq_o, irq_id_o); else n_pass++;
    bus_read(BASE + 32'h200, d);
    n_total++; if (d !== 32'hC) $display("FAIL prio_pending_reg: got %0h expected c", d); else n_pass++;
    bus_write(BASE + 32'h204, 32'hF, 4'h1);
  endtask

  task automatic test_ack_corners();
    irq_ack_i = 1'b1; irq_id_i = 5'd25;
    tick(1);
    n_total++; if (pending_o !== 4'hC) $display("FAIL ack_out_of_range: got %0h expected c", pending_o); else n_pass++;
    irq_id_i = 5'd16;
    tick(1);
    n_total++; if (pending_o !== 4'hC) $display("FAIL ack_not_pending: got %0h expected c", pending_o); else n_pass++;
    irq_id_i = 5'd18;
    tick(1);
    irq_ack_i = 1'b0;
    n_total++; if ({pending_o, irq_id_o} !== {4'h8, 5'd19}) $display("FAIL ack_advance: got pend=%0h id=%0d expected 8/19", pending_o, irq_id_o); else n_pass++;
    bus_write(ra(0, 0), 32'd2, 4'hF);
    bus_write(ra(0, 1), 32'h3, 4'h1);
    tick(3);
    n_total++; if (pending_o[0] !== 1'b1) $display("FAIL ack_setup: got %0b expected 1", pending_o[0]); else n_pass++;
    tick(2);
    irq_ack_i = 1'b1; irq_id_i = 5'd16;
    tick(1);
    n_total++; if (pending_o[0] !== 1'b1) $display("FAIL ack_vs_expiry: got %0b expected 1", pending_o[0]); else n_pass++;
    tick(1);
    irq_ack_i = 1'b0;
    n_total++; if (pending_o[0] !== 1'b0) $display("FAIL ack_clear: got %0b expected 0", pending_o[0]); else n_pass++;
    bus_write(ra(0, 1), 32'h0, 4'h1);
    tick(1);
    n_total++; if (pending_o[0] !== 1'b0) $display("FAIL ack_disabled_hold: got %0b expected 0", pending_o[0]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] t_addr [7];
    logic [31:0] t_data [7];
    logic [3:0]  t_be   [7];
    logic        t_we   [7];
    logic [31:0] t_exp  [7];
    do_reset();
    t_addr[0] = ra(3, 0);         t_we[0] = 1'b1; t_data[0] = 32'hAABB_CCDD; t_be[0] = 4'h1; t_exp[0] = 32'h0;
    t_addr[1] = ra(3, 0);         t_we[1] = 1'b0; t_data[1] = 32'h0;         t_be[1] = 4'hF; t_exp[1] = 32'h0000_00DD;
    t_addr[2] = BASE + 32'h3F0;   t_we[2] = 1'b0; t_data[2] = 32'h0;         t_be[2] = 4'hF; t_exp[2] = 32'h0;
    t_addr[3] = BASE + 32'h204;   t_we[3] = 1'b0; t_data[3] = 32'h0;         t_be[3] = 4'hF; t_exp[3] = 32'h0000_000F;
    t_addr[4] = BASE + 32'h3F0;   t_we[4] = 1'b1; t_data[4] = 32'hFFFF_FFFF; t_be[4] = 4'hF; t_exp[4] = 32'h0;
    t_addr[5] = ra(3, 0);         t_we[5] = 1'b1; t_data[5] = 32'h1122_3344; t_be[5] = 4'h6; t_exp[5] = 32'h0;
    t_addr[6] = ra(3, 0);         t_we[6] = 1'b0; t_data[6] = 32'h0;         t_be[6] = 4'hF; t_exp[6] = 32'h0022_33DD;
    for (int i = 0; i <= 7; i++) begin
      if (i > 0) begin
        n_total++; if (bus.rvalid_o !== 1'b1) $display("FAIL b2b_rvalid[%0d]: got %0b expected 1", i - 1, bus.rvalid_o); else n_pass++;
        if (!t_we[i-1]) begin
          n_total++; if (bus.rdata_o !== t_exp[i-1]) $display("FAIL b2b_rdata[%0d]: got %0h expected %0h", i - 1, bus.rdata_o, t_exp[i-1]); else n_pass++;
        end
      end
      if (i < 7) begin
        bus.req_i = 1'b1; bus.we_i = t_we[i]; bus.addr_i = t_addr[i]; bus.wdata_i = t_data[i]; bus.be_i = t_be[i];
      end else begin
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = 4'h0;
      end
      #4;
      n_total++; if (bus.gnt_o !== bus.req_i) $display("FAIL b2b_gnt[%0d]: got %0b expected %0b", i, bus.gnt_o, bus.req_i); else n_pass++;
      tick(1);
    end
    n_total++; if ({bus.rvalid_o, bus.rdata_o} !== '0) $display("FAIL b2b_idle: got rvalid=%0b rdata=%0h expected 0", bus.rvalid_o, bus.rdata_o); else n_pass++;
  endtask

  task automatic test_random();
    logic [NUM_IRQ-1:0]  model_pend, nxt, mask, m;
    logic [ID_WIDTH-1:0] exp_id;
    logic                ack;
    int                  ack_id;
    do_reset();
    for (int n = 0; n < NUM_IRQ; n++) begin
      rl[n]   = int'($urandom_range(0, 7));
      rper[n] = bit'($urandom_range(0, 1));
      bus_write(ra(n, 0), 32'(rl[n]), 4'hF);
    end
    mask = NUM_IRQ'($urandom_range(1, 15));
    bus_write(BASE + 32'h204, 32'(mask), 4'hF);
    model_pend = '0;
    for (int c = 0; c < 60; c++) begin
      m = model_pend & mask;
      exp_id = '0;
      for (int n = NUM_IRQ - 1; n >= 0; n--) if (m[n]) exp_id = ID_WIDTH'(ID_OFFSET + n);
      n_total++; if (pending_o !== model_pend) $display("FAIL rand_pending c=%0d: got %0h expected %0h", c, pending_o, model_pend); else n_pass++;
      n_total++; if ({irq_o, irq_id_o} !== {|m, exp_id}) $display("FAIL rand_irq c=%0d: got irq=%0b id=%0d expected %0b/%0d", c, irq_o, irq_id_o, |m, exp_id); else n_pass++;
      ack = 1'b0;
      ack_id = 0;
      if (c < NUM_IRQ) begin
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = ra(c, 1); bus.be_i = 4'h1;
        bus.wdata_i = {30'b0, rper[c], 1'b1};
      end else begin
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = 4'h0;
        ack = ($urandom_range(0, 2) == 0);
        ack_id = int'($urandom_range(14, 22));
      end
      irq_ack_i = ack;
      irq_id_i = ID_WIDTH'(ack_id);
      for (int n = 0; n < NUM_IRQ; n++) begin
        nxt[n] = fires(n, c + 1) | (model_pend[n] & !(ack && (ack_id == ID_OFFSET + n)));
      end
      tick(1);
      model_pend = nxt;
    end
    irq_ack_i = 1'b0;
    bus.req_i = 1'b0; bus.we_i = 1'b0;
  endtask

  initial begin
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.be_i = '0; bus.wdata_i = '0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_priority_mask();
    test_ack_corners();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tb_irq_timer_bank.md
# tb_irq_timer_bank

Memory-mapped, multi-channel interrupt generator for the core testbench, the parametrised successor to the single hard-wired irq/irq_id path between the core and the testbench RAM model. It provides NUM_IRQ independent down-counting timers (one-shot or periodic), a maskable pending register, fixed-priority arbitration onto the core's irq/irq_id interface and an ack handshake that clears the serviced source. It sits on the data bus next to the RAM model, decoded at BASE_ADDR.

## Interface
- NUM_IRQ, 4: timer channels, 1..16.
- CNT_WIDTH, 32: counter/load width, 1..32; register reads zero-extend.
- ID_WIDTH, 5: width of irq id.
- ID_OFFSET, 16: irq id of channel 0; channel n reports ID_OFFSET+n (truncated to ID_WIDTH).
- BASE_ADDR, 32'h1500_0000: base of the 1 KiB register window.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  bus request.
- addr_i  in  32  byte address.
- we_i  in  1  write enable.
- be_i  in  4  byte enables.
- wdata_i  in  32  write data.
- gnt_o  out  1  grant.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- irq_o  out  1  interrupt request.
- irq_id_o  out  ID_WIDTH  id of the highest-priority pending source.
- irq_ack_i  in  1  core acknowledges.
- irq_id_i  in  ID_WIDTH  id being acknowledged.
- pending_o  out  NUM_IRQ  raw pending bits (debug/bench).

## Operation
- Register map (offset from BASE_ADDR). Channel n at 0x10*n: +0x0 LOAD (rw, byte-enabled); +0x4 CTRL (rw, bit0 EN, bit1 PERIODIC, only be_i[0] honoured); +0x8 COUNT (ro); +0xC STATUS (bit0 pending, write 1 clears). Global: 0x200 PENDING (ro), 0x204 MASK (rw, byte-enabled).
- Unmapped/reserved offsets and channels >= NUM_IRQ: writes ignored, reads return 0.
- Per-channel FSM: IDLE -> RUN on CTRL write with EN=1 (COUNT <= LOAD). RUN: COUNT decrements each cycle while COUNT != 0. RUN with COUNT == 0: pending <= 1; PERIODIC=1: COUNT <= LOAD, stay RUN; PERIODIC=0: EN <= 0, go IDLE. CTRL write with EN=0: -> IDLE, COUNT holds, pending unchanged. LOAD write while RUN affects only the next reload.
- irq_o = |(pending & MASK). irq_id_o = ID_OFFSET + lowest-index channel with pending & MASK; 0 when irq_o=0.
- Ack: irq_ack_i=1 clears pending of channel (irq_id_i - ID_OFFSET) at next edge; id out of range or channel not pending: ignored.
- Simultaneous set and clear (timer expiry vs ack or STATUS W1C) on the same channel: set wins.
- Arithmetic: counters are unsigned CNT_WIDTH; no wrap below 0.

## Timing
- gnt_o = req_i (combinational, zero wait states). Every granted access returns rvalid_o=1 exactly one cycle later; rdata_o is valid then, 0 otherwise. Back-to-back requests sustain one per cycle.
- Register writes take effect at the edge ending the grant cycle T.
- CTRL enable written in cycle T with LOAD=L: pending_o and irq_o rise in cycle T+L+2 (L=0: T+2). Periodic period L+1 cycles.
- irq_o/irq_id_o are combinational from registered pending and MASK: no added latency. Ack in cycle A: irq_o falls (or irq_id_o advances) in A+1.
- Reset: all outputs 0; LOAD, COUNT, CTRL, pending 0; MASK all-ones; all FSMs IDLE; rst_i during a transaction drops the pending rvalid.

## Test plan
- Reset: hold rst_i 3 cycles mid-count -> all outputs 0, MASK reads 0x0000000F (NUM_IRQ=4), COUNT reads 0.
- One-shot: LOAD0=5, CTRL0=0x1 at cycle T -> irq_o=1, irq_id_o=16 at T+7; ack id 16 -> irq_o=0 next cycle; CTRL0 reads 0x0.
- Periodic: LOAD1=3, CTRL1=0x3 -> pending_o[1] sets every 4 cycles; W1C STATUS in the expiry cycle -> pending remains 1.
- Priority/mask: channels 2 and 3 pending -> irq_id_o=18; MASK=0x8 -> irq_id_o=19; MASK=0 -> irq_o=0, PENDING reads 0xC.
- Ack corner cases: ack id 25 or ack of non-pending channel -> no change; ack on expiry cycle -> pending stays 1.
- Bus: back-to-back read/write/unmapped read at BASE+0x3F0 -> gnt_o each cycle, rvalid_o one cycle later, unmapped returns 0, be_i=0x1 on LOAD writes only byte 0.
